mmio_note_seq: RTL and testbench

// MMIO slot core that schedules notes for the DDFS/ADSR audio path: CPU queues {FCW, duration} entries in a FIFO.

---
 rtl/note_seq_pkg.sv | 31 +++
 rtl/fifo_sync.sv | 60 ++++++
 rtl/mmio_note_seq.sv | 178 +++++++++++++++++
 tb/tb_mmio_note_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// rtl/note_seq_pkg.sv - shared types and register map for the note sequencer
package note_seq_pkg;

    localparam logic [4:0] ADDR_PUSH = 5'd0;
    localparam logic [4:0] ADDR_FCW  = 5'd1;
    localparam logic [4:0] ADDR_CTRL = 5'd2;
    localparam logic [4:0] ADDR_TDIV = 5'd3;
    localparam logic [4:0] ADDR_GAP  = 5'd4;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    typedef struct packed {
        logic [31:0] fcw;
        logic [15:0] dur;
    } note_t;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    // A zero duration still plays for one tick
    function automatic logic [15:0] dur_min1(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

    // A zero divider behaves as divide-by-one
    function automatic logic [31:0] div_min1(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock first-word-fall-through FIFO with flush
module fifo_sync #(
    parameter int WIDTH = 48,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // Flush overrides both ports; writes into a full FIFO are dropped
    assign w_push = push && !full && !flush;
    assign w_pop  = pop && !empty && !flush;

    assign full  = r_count[AW];
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rptr];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_note_seq.sv
// rtl/mmio_note_seq.sv - MMIO note scheduler driving DDFS fcw and ADSR gate
module mmio_note_seq
    import note_seq_pkg::*;
#(
    parameter int          FIFO_AW      = 4,
    parameter logic [31:0] TICK_DIV_RST = 32'd100000,
    parameter logic [15:0] GAP_RST      = 16'd10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic [31:0] fcw,
    output logic        gate,
    output logic        note_start
);

    logic [31:0]    r_fcw_stage;
    logic [31:0]    r_tick_div;
    logic [15:0]    r_gap;
    logic           r_enable;
    logic           r_ovf;
    state_t         r_state;
    logic [31:0]    r_fcw;
    logic [31:0]    r_tdiv_lat;
    logic [31:0]    r_presc;
    logic [15:0]    r_dcnt;
    logic [15:0]    r_gcnt;
    logic           r_note_start;

    logic           w_wr;
    logic           w_ctrl_wr;
    logic           w_push_req;
    logic           w_push_ok;
    logic           w_flush;
    logic           w_clr_ovf;
    logic           w_full;
    logic           w_empty;
    logic [FIFO_AW:0] w_count;
    note_t          w_entry;
    note_t          w_head;
    logic           w_tick;
    logic           w_gap_exit;
    logic           w_load;
    logic [31:0]    w_status;
    logic           w_unused_read;

    // Reads are side-effect free, so the read strobe carries no information
    assign w_unused_read = read;

    assign w_wr       = cs && write;
    assign w_ctrl_wr  = w_wr && (addr == ADDR_CTRL);
    assign w_push_req = w_wr && (addr == ADDR_PUSH);
    assign w_flush    = w_ctrl_wr && write_data[CTRL_FLUSH];
    assign w_clr_ovf  = w_ctrl_wr && write_data[CTRL_CLR_OVF];
    assign w_push_ok  = w_push_req && !w_full && !w_flush;
    assign w_entry    = '{fcw: r_fcw_stage, dur: write_data[15:0]};

    fifo_sync #(
        .WIDTH ($bits(note_t)),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push_req),
        .pop     (w_load),
        .flush   (w_flush),
        .wdata   (w_entry),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_tick     = (r_presc == div_min1(r_tdiv_lat) - 32'd1);
    assign w_gap_exit = (r_state == GAP) &&
                        ((r_gcnt == 16'd0) || ((r_gcnt == 16'd1) && w_tick));
    // The last gap cycle loads the next note directly so a zero gap
    // leaves exactly one low gate cycle between back-to-back notes
    assign w_load     = !w_flush && !w_empty &&
                        ((r_state == LOAD) || (w_gap_exit && r_enable));

    assign fcw        = r_fcw;
    assign gate       = (r_state == PLAY);
    assign note_start = r_note_start;

    // Configuration registers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fcw_stage <= 32'd0;
            r_tick_div  <= TICK_DIV_RST;
            r_gap       <= GAP_RST;
            r_enable    <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_wr && (addr == ADDR_FCW))  r_fcw_stage <= write_data;
            if (w_wr && (addr == ADDR_TDIV)) r_tick_div  <= write_data;
            if (w_wr && (addr == ADDR_GAP))  r_gap       <= write_data[15:0];
            if (w_ctrl_wr)                   r_enable    <= write_data[CTRL_EN];
            if (w_clr_ovf)                   r_ovf       <= 1'b0;
            if (w_push_req && w_full && !w_flush) r_ovf  <= 1'b1;
        end
    end

    // Sequencer: pop a note, hold gate for its duration, then a silent gap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_fcw        <= 32'd0;
            r_tdiv_lat   <= 32'd0;
            r_presc      <= 32'd0;
            r_dcnt       <= 16'd0;
            r_gcnt       <= 16'd0;
            r_note_start <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            if (w_flush) begin
                r_state <= IDLE;
            end else if (w_load) begin
                r_state      <= PLAY;
                r_fcw        <= w_head.fcw;
                r_dcnt       <= dur_min1(w_head.dur);
                r_tdiv_lat   <= r_tick_div;
                r_presc      <= 32'd0;
                r_note_start <= 1'b1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_enable && (!w_empty || w_push_ok)) r_state <= LOAD;
                    end
                    PLAY: begin
                        r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
                        if (w_tick) begin
                            if (r_dcnt == 16'd1) begin
                                r_state <= GAP;
                                r_gcnt  <= r_gap;
                                r_presc <= 32'd0;
                            end else begin
                                r_dcnt <= r_dcnt - 16'd1;
                            end
                        end
                    end
                    GAP: begin
                        if (w_gap_exit) begin
                            r_state <= IDLE;
                        end else begin
                            r_presc <= w_tick ? 32'd0 : r_presc + 32'd1;
                            if (w_tick) r_gcnt <= r_gcnt - 16'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Status word and register readback
    always_comb begin
        w_status                  = 32'd0;
        w_status[8 +: FIFO_AW+1]  = w_count;
        w_status[3]               = r_ovf;
        w_status[2]               = (r_state != IDLE);
        w_status[1]               = w_full;
        w_status[0]               = w_empty;
        case (addr)
            ADDR_PUSH: read_data = w_status;
            ADDR_FCW:  read_data = r_fcw_stage;
            ADDR_TDIV: read_data = r_tick_div;
            ADDR_GAP:  read_data = {16'd0, r_gap};
            default:   read_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mmio_note_seq.sv
// tb/tb_mmio_note_seq.sv - directed self-checking bench for mmio_note_seq
module tb_mmio_note_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic [31:0] fcw;
    logic        gate;
    logic        note_start;

    int n_tests = 0;
    int n_fail  = 0;

    int hi_w[$];
    int lo_w[$];
    int fcws[$];
    int ns_cnt;
    int first_hi;
    int timed_out;
    logic [31:0] rd;

    mmio_note_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .fcw        (fcw),
        .gate       (gate),
        .note_start (note_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; read = 1'b0; addr = a; write_data = d;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = a;
        @(negedge clk);
        d = read_data;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic push_note(input logic [31:0] f, input logic [15:0] dur);
        bus_wr(5'd1, f);
        bus_wr(5'd0, {16'd0, dur});
    endtask

    // Samples gate/busy each cycle until the sequencer returns to idle
    task automatic measure(input int budget);
        bit seen;
        int hr;
        int lr;
        int c;
        bit done;
        hi_w.delete(); lo_w.delete(); fcws.delete();
        ns_cnt = 0; first_hi = -1;
        seen = 0; hr = 0; lr = 0; c = 0; done = 0;
        cs = 1'b1; read = 1'b1; write = 1'b0; addr = 5'd0;
        while (!done && c < budget) begin
            @(negedge clk);
            if (note_start) begin
                ns_cnt++;
                fcws.push_back(int'(fcw));
            end
            if (gate) begin
                if (!seen) first_hi = c;
                seen = 1;
                if (lr > 0) lo_w.push_back(lr);
                lr = 0;
                hr++;
            end else begin
                if (hr > 0) hi_w.push_back(hr);
                hr = 0;
                if (seen && read_data[2]) lr++;
                if (seen && !read_data[2]) done = 1;
            end
            c++;
        end
        if (lr > 0) lo_w.push_back(lr);
        timed_out = done ? 0 : 1;
        @(posedge clk); #1;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic wait_gate_hi(input string tag, input int budget);
        int c;
        bit hit;
        c = 0; hit = 0;
        while (!hit && c < budget) begin
            @(negedge clk);
            hit = gate;
            c++;
        end
        check(tag, {31'd0, hit}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        bus_rd(5'd0, rd);  check("rst_status", rd, 32'h0000_0001);
        check("rst_gate", {31'd0, gate}, 32'd0);
        check("rst_fcw", fcw, 32'd0);
        check("rst_nstart", {31'd0, note_start}, 32'd0);
        bus_rd(5'd3, rd);  check("rst_tdiv", rd, 32'd100000);
        bus_rd(5'd4, rd);  check("rst_gap", rd, 32'd10);
        bus_rd(5'd1, rd);  check("rst_fcwstage", rd, 32'd0);

        // Single note: 3 ticks of 4 cycles, gap 2 ticks
        bus_wr(5'd3, 32'd4);
        bus_wr(5'd4, 32'd2);
        bus_wr(5'd1, 32'h00A3_D70A);
        bus_wr(5'd2, 32'd1);
        bus_wr(5'd0, 32'd3);
        measure(200);
        check("t1_timeout", timed_out, 0);
        check("t1_latency", first_hi, 1);
        check("t1_hi_n", hi_w.size(), 1);
        check("t1_hi0", q_at(hi_w, 0), 12);
        check("t1_lo_n", lo_w.size(), 1);
        check("t1_gap", q_at(lo_w, 0), 8);
        check("t1_nstart", ns_cnt, 1);
        check("t1_fcw_start", q_at(fcws, 0), 32'h00A3_D70A);
        check("t1_fcw_hold", fcw, 32'h00A3_D70A);
        bus_rd(5'd0, rd);  check("t1_status", rd, 32'h0000_0001);

        // Three queued notes, zero gap
        bus_wr(5'd2, 32'd0);
        bus_wr(5'd3, 32'd2);
        bus_wr(5'd4, 32'd0);
        push_note(32'h0000_0111, 16'd1);
        push_note(32'h0000_0222, 16'd2);
        push_note(32'h0000_0333, 16'd1);
        bus_wr(5'd2, 32'd1);
        measure(200);
        check("t2_timeout", timed_out, 0);
        check("t2_hi_n", hi_w.size(), 3);
        check("t2_hi0", q_at(hi_w, 0), 2);
        check("t2_hi1", q_at(hi_w, 1), 4);
        check("t2_hi2", q_at(hi_w, 2), 2);
        check("t2_lo0", q_at(lo_w, 0), 1);
        check("t2_lo1", q_at(lo_w, 1), 1);
        check("t2_fcw0", q_at(fcws, 0), 32'h111);
        check("t2_fcw1", q_at(fcws, 1), 32'h222);
        check("t2_fcw2", q_at(fcws, 2), 32'h333);
        bus_rd(5'd0, rd);  check("t2_status", rd, 32'h0000_0001);

        // Overflow with enable off
        bus_wr(5'd2, 32'd0);
        for (int i = 0; i < 17; i++) bus_wr(5'd0, 32'd1);
        bus_rd(5'd0, rd);  check("t3_full_ovf", rd, 32'h0000_100A);
        bus_wr(5'd2, 32'd4);
        bus_rd(5'd0, rd);  check("t3_clr_ovf", rd, 32'h0000_1002);
        bus_wr(5'd0, 32'd1);
        bus_rd(5'd0, rd);  check("t3_ovf_again", rd, 32'h0000_100A);
        bus_wr(5'd2, 32'd2);
        bus_rd(5'd0, rd);  check("t3_flush_keeps_ovf", rd, 32'h0000_0009);
        bus_wr(5'd2, 32'd4);
        bus_rd(5'd0, rd);  check("t3_clean", rd, 32'h0000_0001);

        // Flush during the first of four notes
        bus_wr(5'd3, 32'd4);
        for (int i = 0; i < 4; i++) push_note(32'h1000 + i, 16'd5);
        bus_wr(5'd2, 32'd1);
        wait_gate_hi("t4_gate_rise", 20);
        bus_wr(5'd2, 32'd3);
        @(negedge clk);
        check("t4_gate_drop", {31'd0, gate}, 32'd0);
        @(posedge clk); #1;
        bus_rd(5'd0, rd);  check("t4_status", rd, 32'h0000_0001);
        ns_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (note_start) ns_cnt++;
        end
        @(posedge clk); #1;
        check("t4_no_nstart", ns_cnt, 0);
        bus_wr(5'd2, 32'd0);

        // Zero duration with zero divider plays for one cycle
        bus_wr(5'd3, 32'd0);
        bus_wr(5'd4, 32'd0);
        bus_wr(5'd2, 32'd1);
        push_note(32'h0000_0ABC, 16'd0);
        measure(50);
        check("t5_timeout", timed_out, 0);
        check("t5_hi_n", hi_w.size(), 1);
        check("t5_hi0", q_at(hi_w, 0), 1);

        // Enable cleared mid-note: note and gap finish, queue untouched
        bus_wr(5'd2, 32'd0);
        bus_wr(5'd3, 32'd4);
        bus_wr(5'd4, 32'd1);
        for (int i = 0; i < 3; i++) push_note(32'h2000 + i, 16'd4);
        bus_wr(5'd2, 32'd1);
        wait_gate_hi("t6_gate_rise", 20);
        bus_wr(5'd2, 32'd0);
        measure(100);
        check("t6_timeout", timed_out, 0);
        check("t6_hi_n", hi_w.size(), 1);
        check("t6_gap", q_at(lo_w, 0), 4);
        check("t6_nstart", ns_cnt, 0);
        bus_rd(5'd0, rd);  check("t6_status", rd, 32'h0000_0200);
        bus_wr(5'd2, 32'd2);
        bus_rd(5'd0, rd);  check("t6_flushed", rd, 32'h0000_0001);

        // Reset while a note is playing
        bus_wr(5'd2, 32'd1);
        push_note(32'h0000_5555, 16'd10);
        wait_gate_hi("t7_gate_rise", 20);
        check("t7_fcw_playing", fcw, 32'h0000_5555);
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t7_gate", {31'd0, gate}, 32'd0);
        check("t7_fcw", fcw, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        bus_rd(5'd0, rd);  check("t7_status", rd, 32'h0000_0001);
        bus_rd(5'd3, rd);  check("t7_tdiv", rd, 32'd100000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
